// File: rtl/mux3to1.sv
// Fetch-stage next-PC selector: combinational 3:1 mux plus a registered copy
// and a sticky flag recording that the illegal select code was ever sampled.
module mux3to1 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sel,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err
);

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_q_d;
  logic             sel_err_q;
  logic             sel_err_d;
  logic             illegal_sel;

  // The illegal code falls through to the sequential PC so fetch never stalls.
  always_comb begin
    mux_d = in0;
    unique case (sel)
      SEL_PC4:     mux_d = in0;
      SEL_JUMP:    mux_d = in1;
      SEL_BRANCH:  mux_d = in2;
      SEL_ILLEGAL: mux_d = in0;
      default:     mux_d = in0;
    endcase
  end

  assign out         = mux_d;
  assign illegal_sel = (sel == SEL_ILLEGAL);

  // Setting the flag takes priority over clearing it on the same edge.
  always_comb begin
    out_q_d   = mux_d;
    sel_err_d = sel_err_q;
    if (clr_err) begin
      sel_err_d = 1'b0;
    end
    if (illegal_sel) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q     <= RESET_VAL;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out_q_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux3to1.sv
// Directed bench for mux3to1: stimulus pushes expected values into a queue,
// a monitor process pops and compares them against the DUT outputs.
module tb_mux3to1;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0, in1, in2;
  logic [1:0]   sel;
  logic         clr_err;
  logic [W-1:0] out, out_q;
  logic         sel_err;

  mux3to1 #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sel(sel),
    .clr_err(clr_err), .out(out), .out_q(out_q), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sig: 0 = out, 1 = out_q, 2 = sel_err
  typedef struct {
    string        name;
    int           sig;
    logic [W-1:0] exp;
  } exp_t;

  exp_t  sb_q[$];
  event  check_ev;
  int    total = 0;
  int    bad   = 0;

  task automatic expect_val(input string name, input int sig, input logic [W-1:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Hand the pending expectations to the monitor and give it time to compare.
  task automatic check();
    -> check_ev;
    #2;
  endtask

  always begin
    @(check_ev);
    #1;
    while (sb_q.size() > 0) begin
      exp_t         e;
      logic [W-1:0] act;
      e = sb_q.pop_front();
      case (e.sig)
        0:       act = out;
        1:       act = out_q;
        default: act = {{(W-1){1'b0}}, sel_err};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; sel = 2'd1; clr_err = 1'b0;
    in0 = '0; in1 = 32'h0000_1000; in2 = '0;
    #1;
    expect_val("reset_out_comb", 0, 32'h1000);
    expect_val("reset_out_q",    1, 32'h0);
    expect_val("reset_sel_err",  2, 32'h0);
    check();

    // Illegal select during reset must not set the flag.
    @(negedge clk); sel = 2'd3;
    @(posedge clk); #1;
    expect_val("reset_hold_out_q",   1, 32'h0);
    expect_val("reset_hold_sel_err", 2, 32'h0);
    expect_val("reset_sel3_out",     0, 32'h0);
    check();

    // Select sweep
    @(negedge clk);
    rst = 1'b1; sel = 2'd0; in0 = 32'd4; in1 = 32'h100; in2 = 32'h200;
    #1; expect_val("sweep_out_sel0", 0, 32'd4); check();
    @(posedge clk); #1; expect_val("sweep_q_sel0", 1, 32'd4); check();
    @(negedge clk); sel = 2'd1;
    #1; expect_val("sweep_out_sel1", 0, 32'h100); check();
    @(posedge clk); #1;
    expect_val("sweep_q_sel1", 1, 32'h100);
    expect_val("sweep_err_sel1", 2, 32'h0);
    check();
    @(negedge clk); sel = 2'd2;
    #1; expect_val("sweep_out_sel2", 0, 32'h200); check();
    @(posedge clk); #1; expect_val("sweep_q_sel2", 1, 32'h200); check();
    @(negedge clk); sel = 2'd3;
    #1; expect_val("sweep_out_sel3", 0, 32'd4); check();
    @(posedge clk); #1;
    expect_val("sweep_q_sel3",   1, 32'd4);
    expect_val("illegal_set",    2, 32'h1);
    check();

    // Sticky, then clear
    @(negedge clk); sel = 2'd0;
    @(posedge clk); #1; expect_val("illegal_sticky", 2, 32'h1); check();
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1; expect_val("clear_err", 2, 32'h0); check();

    // Set/clear collision
    @(negedge clk); sel = 2'd3; clr_err = 1'b1;
    @(posedge clk); #1; expect_val("collision_set_wins", 2, 32'h1); check();
    @(negedge clk); sel = 2'd2; clr_err = 1'b0;
    @(posedge clk); #1;
    expect_val("pre_async_out_q", 1, 32'h200);
    expect_val("pre_async_err",   2, 32'h1);
    check();

    // Async reset between edges
    @(negedge clk); rst = 1'b0;
    #1;
    expect_val("async_out_q",   1, 32'h0);
    expect_val("async_sel_err", 2, 32'h0);
    expect_val("async_out",     0, 32'h200);
    check();
    in2 = 32'h300;
    #1; expect_val("async_out_tracks", 0, 32'h300); check();
    @(negedge clk); rst = 1'b1; sel = 2'd0; in0 = 32'd8;
    @(posedge clk); #1; expect_val("release_load", 1, 32'd8); check();

    // Fetch loop: in0 = out_q + 4 from reset
    @(negedge clk); rst = 1'b0; sel = 2'd0;
    #1; in0 = out_q + 32'd4;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; in0 = out_q + 32'd4;
    expect_val("fetch_step1", 1, 32'd4);  check();
    @(posedge clk); #1; in0 = out_q + 32'd4;
    expect_val("fetch_step2", 1, 32'd8);  check();
    @(posedge clk); #1; in0 = out_q + 32'd4;
    expect_val("fetch_step3", 1, 32'd12); check();

    #5;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
